// File: rtl/calc_pkg.sv
// Shared types and constants for the decimal calculator sequencing path.
package calc_pkg;

    typedef enum logic [2:0] {
        ENTER_A,
        ENTER_B,
        ADD,
        CONV,
        SHOW
    } state_t;

    localparam logic [1:0] DISP_A = 2'd0;
    localparam logic [1:0] DISP_B = 2'd1;
    localparam logic [1:0] DISP_R = 2'd2;

    localparam logic [3:0] MAX_DIGIT = 4'd9;

endpackage

// File: rtl/acumulador_digitos.sv
// One decimal operand built digit by digit in binary (value*10 + digit),
// with its digit counter and accept/reject detection.
module acumulador_digitos
    import calc_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int WIDTH  = 12,
    parameter int CW     = $clog2(DIGITS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [3:0]       digit,
    output logic [WIDTH-1:0] value,
    output logic [CW-1:0]    count,
    output logic             accept,
    output logic             reject
);

    localparam logic [CW-1:0] FULL = CW'(DIGITS);

    logic [WIDTH-1:0] base_value;
    logic [CW-1:0]    base_count;

    // Clear and load together start a fresh operand with this digit as its first.
    always_comb begin
        base_value = clear ? '0 : value;
        base_count = clear ? '0 : count;
        accept     = load && (digit <= MAX_DIGIT) && (base_count < FULL);
        reject     = load && !accept;
    end

    // NOTE: registered state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
            count <= '0;
        end else if (accept) begin
            value <= (base_value * WIDTH'(10)) + WIDTH'(digit);
            count <= base_count + CW'(1);
        end else if (clear) begin
            value <= '0;
            count <= '0;
        end
    end

endmodule

// File: rtl/control_calculadora.sv
// Sequencer for the two-operand decimal adder: operand entry, adder fire,
// converter start/done handshake and display source selection.
module control_calculadora
    import calc_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int WIDTH  = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       digit_in,
    input  logic             digit_btn,
    input  logic             suma_btn,
    input  logic [WIDTH:0]   resultado,
    input  logic             conv_done,
    output logic [WIDTH-1:0] first_num,
    output logic [WIDTH-1:0] second_num,
    output logic             add_en,
    output logic             conv_start,
    output logic [WIDTH:0]   conv_operand,
    output logic [1:0]       disp_sel,
    output logic             digit_err
);

    localparam int CW = $clog2(DIGITS + 1);

    state_t        state, state_next;
    logic [1:0]    disp_sel_next;
    logic          add_en_next, conv_start_next, digit_err_next;
    logic          conv_busy, conv_busy_next, conv_pend, conv_pend_next;
    logic          conv_req;
    logic          clear_a, load_a, accept_a, reject_a;
    logic          clear_b, load_b, accept_b, reject_b;
    logic [CW-1:0] count_a, count_b;

    acumulador_digitos #(.DIGITS(DIGITS), .WIDTH(WIDTH), .CW(CW)) u_acc_a (
        .clk(clk), .rst(rst), .clear(clear_a), .load(load_a), .digit(digit_in),
        .value(first_num), .count(count_a), .accept(accept_a), .reject(reject_a)
    );

    acumulador_digitos #(.DIGITS(DIGITS), .WIDTH(WIDTH), .CW(CW)) u_acc_b (
        .clk(clk), .rst(rst), .clear(clear_b), .load(load_b), .digit(digit_in),
        .value(second_num), .count(count_b), .accept(accept_b), .reject(reject_b)
    );

    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned and infers a latch.
    always_comb begin
        state_next    = state;
        disp_sel_next = disp_sel;
        add_en_next   = 1'b0;
        clear_a       = 1'b0;
        load_a        = 1'b0;
        clear_b       = 1'b0;
        load_b        = 1'b0;
        conv_req      = 1'b0;

        // suma_btn always outranks a simultaneous digit_btn.
        case (state)
            ENTER_A: begin
                if (suma_btn) begin
                    if (count_a != '0) begin
                        state_next    = ENTER_B;
                        disp_sel_next = DISP_B;
                        clear_b       = 1'b1;
                        conv_req      = 1'b1;
                    end
                end else if (digit_btn) begin
                    load_a   = 1'b1;
                    conv_req = accept_a;
                end
            end
            ENTER_B: begin
                if (suma_btn) begin
                    if (count_b != '0) begin
                        state_next  = ADD;
                        add_en_next = 1'b1;
                    end
                end else if (digit_btn) begin
                    load_b   = 1'b1;
                    conv_req = accept_b;
                end
            end
            ADD: begin
                disp_sel_next = DISP_R;
                state_next    = CONV;
                conv_req      = 1'b1;
            end
            CONV: begin
                // With nothing pending, the running conversion is the sum's.
                if (conv_done && conv_busy && !conv_pend) state_next = SHOW;
            end
            SHOW: begin
                if (digit_btn && !suma_btn) begin
                    clear_a       = 1'b1;
                    clear_b       = 1'b1;
                    load_a        = 1'b1;
                    state_next    = ENTER_A;
                    disp_sel_next = DISP_A;
                    conv_req      = accept_a;
                end
            end
            default: state_next = ENTER_A;
        endcase

        digit_err_next = reject_a || reject_b;

        conv_start_next = 1'b0;
        conv_busy_next  = conv_busy;
        conv_pend_next  = conv_pend;
        if (conv_req) begin
            if (!conv_busy || conv_done) begin
                conv_start_next = 1'b1;
                conv_busy_next  = 1'b1;
                conv_pend_next  = 1'b0;
            end else begin
                conv_pend_next  = 1'b1;
            end
        end else if (conv_done && conv_busy) begin
            if (conv_pend) begin
                conv_start_next = 1'b1;
                conv_pend_next  = 1'b0;
            end else begin
                conv_busy_next  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ENTER_A;
            disp_sel   <= DISP_A;
            add_en     <= 1'b0;
            conv_start <= 1'b0;
            digit_err  <= 1'b0;
            conv_busy  <= 1'b0;
            conv_pend  <= 1'b0;
        end else begin
            state      <= state_next;
            disp_sel   <= disp_sel_next;
            add_en     <= add_en_next;
            conv_start <= conv_start_next;
            digit_err  <= digit_err_next;
            conv_busy  <= conv_busy_next;
            conv_pend  <= conv_pend_next;
        end
    end

    always_comb begin
        case (disp_sel)
            DISP_A:  conv_operand = {1'b0, first_num};
            DISP_B:  conv_operand = {1'b0, second_num};
            DISP_R:  conv_operand = resultado;
            default: conv_operand = '0;
        endcase
    end

endmodule

// File: tb/tb_control_calculadora.sv
// Bench for control_calculadora: bench-side adder and converter, a per-cycle
// behavioural model, directed scenarios and a randomized run.
module tb_control_calculadora;

    localparam int PH_A = 0, PH_B = 1, PH_ADD = 2, PH_CONV = 3, PH_SHOW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  digit_in = 4'd0;
    logic        digit_btn = 1'b0;
    logic        suma_btn = 1'b0;
    logic [12:0] resultado = 13'd0;
    logic        conv_done = 1'b0;
    logic [11:0] first_num, second_num;
    logic        add_en, conv_start, digit_err;
    logic [12:0] conv_operand;
    logic [1:0]  disp_sel;

    control_calculadora #(.DIGITS(3), .WIDTH(12)) dut (
        .clk(clk), .rst(rst), .digit_in(digit_in), .digit_btn(digit_btn),
        .suma_btn(suma_btn), .resultado(resultado), .conv_done(conv_done),
        .first_num(first_num), .second_num(second_num), .add_en(add_en),
        .conv_start(conv_start), .conv_operand(conv_operand),
        .disp_sel(disp_sel), .digit_err(digit_err)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int cyc = 0;
    int n_add = 0, n_start = 0, n_err = 0;

    // Model of what the outputs must be in the current cycle.
    int m_phase = PH_A, m_a = 0, m_b = 0, m_na = 0, m_nb = 0, m_sel = 0, m_sum = 0;
    int m_add = 0, m_err = 0, m_start = 0;
    int m_running = 0, m_waiting = 0;

    // Converter stand-in.
    int conv_delay = 5, rand_delay = 0, rem = 0;
    int last_start_op = -1, last_start_gap = -1, last_done_cyc = -100;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Registered adder: latches the sum one cycle after add_en.
    always @(posedge clk) if (add_en) resultado <= {1'b0, first_num} + {1'b0, second_num};

    initial forever begin
        @(negedge clk);
        conv_done = 1'b0;
        if (rem > 0) begin
            rem--;
            if (rem == 0) begin
                conv_done = 1'b1;
                last_done_cyc = cyc;
            end
        end
        if (conv_start === 1'b1) begin
            last_start_op  = int'(conv_operand);
            last_start_gap = cyc - last_done_cyc;
            rem = rand_delay != 0 ? int'($urandom_range(1, 8)) : conv_delay;
        end
    end

    task automatic model_step();
        int req;
        req = 0;
        m_add = 0; m_err = 0; m_start = 0;
        if (rst) begin
            m_phase = PH_A; m_a = 0; m_b = 0; m_na = 0; m_nb = 0; m_sel = 0;
            m_running = 0; m_waiting = 0;
            return;
        end
        case (m_phase)
            PH_A, PH_B: begin
                if (suma_btn) begin
                    if (m_phase == PH_A && m_na > 0) begin
                        m_phase = PH_B; m_sel = 1; m_b = 0; m_nb = 0; req = 1;
                    end else if (m_phase == PH_B && m_nb > 0) begin
                        m_phase = PH_ADD; m_add = 1; m_sum = m_a + m_b;
                    end
                end else if (digit_btn) begin
                    if (m_phase == PH_A && digit_in <= 9 && m_na < 3) begin
                        m_a = m_a * 10 + int'(digit_in); m_na++; req = 1;
                    end else if (m_phase == PH_B && digit_in <= 9 && m_nb < 3) begin
                        m_b = m_b * 10 + int'(digit_in); m_nb++; req = 1;
                    end else begin
                        m_err = 1;
                    end
                end
            end
            PH_ADD: begin
                m_sel = 2; m_phase = PH_CONV; req = 1;
            end
            PH_CONV: begin
                if (conv_done && m_running != 0 && m_waiting == 0) m_phase = PH_SHOW;
            end
            default: begin
                if (digit_btn && !suma_btn) begin
                    m_a = 0; m_b = 0; m_na = 0; m_nb = 0; m_sel = 0; m_phase = PH_A;
                    if (digit_in <= 9) begin
                        m_a = int'(digit_in); m_na = 1; req = 1;
                    end else begin
                        m_err = 1;
                    end
                end
            end
        endcase
        if (req != 0) begin
            if (m_running == 0 || conv_done) begin
                m_start = 1; m_running = 1; m_waiting = 0;
            end else begin
                m_waiting = 1;
            end
        end else if (conv_done && m_running != 0) begin
            if (m_waiting != 0) begin
                m_start = 1; m_waiting = 0;
            end else begin
                m_running = 0;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        int exp_op;
        @(posedge clk);
        #1;
        cyc++;
        exp_op = m_sel == 0 ? m_a : (m_sel == 1 ? m_b : m_sum);
        check("first_num", first_num, m_a);
        check("second_num", second_num, m_b);
        check("disp_sel", disp_sel, m_sel);
        check("add_en", add_en, m_add);
        check("conv_start", conv_start, m_start);
        check("digit_err", digit_err, m_err);
        check("conv_operand", conv_operand, exp_op);
        n_add   += int'(add_en === 1'b1);
        n_start += int'(conv_start === 1'b1);
        n_err   += int'(digit_err === 1'b1);
    end

    task automatic press_digit(input logic [3:0] d);
        @(negedge clk);
        digit_in = d; digit_btn = 1'b1;
        @(negedge clk);
        digit_btn = 1'b0;
    endtask

    task automatic press_suma();
        @(negedge clk);
        suma_btn = 1'b1;
        @(negedge clk);
        suma_btn = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_phase(input string name, input int target, input int budget);
        for (int i = 0; i < budget && m_phase != target; i++) @(negedge clk);
        check(name, m_phase, target);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_add, b_err, b_start;
        idle(3);
        check("reset_first", first_num, 0);
        check("reset_disp_sel", disp_sel, 0);
        rst = 1'b0;

        // 123 + 456 with a 5-cycle converter.
        conv_delay = 5;
        b_add = n_add;
        press_digit(1); press_digit(2); press_digit(3);
        idle(12);
        press_suma();
        press_digit(4); press_digit(5); press_digit(6);
        idle(12);
        press_suma();
        wait_phase("reach_show", PH_SHOW, 100);
        check("sum_first", first_num, 123);
        check("sum_second", second_num, 456);
        check("sum_add_pulses", n_add - b_add, 1);
        check("sum_conv_operand", last_start_op, 579);
        check("sum_disp_sel", disp_sel, 2);
        press_suma();
        idle(2);
        check("show_ignores_suma", n_add - b_add, 1);

        // A digit in SHOW restarts A; 9,9,9,9 rejects only the fourth.
        b_err = n_err;
        press_digit(9); press_digit(9); press_digit(9);
        check("nines_no_err", n_err - b_err, 0);
        check("nines_value", first_num, 999);
        check("nines_b_cleared", second_num, 0);
        press_digit(9);
        check("fourth_nine_err", n_err - b_err, 1);
        check("fourth_nine_value", first_num, 999);

        // Out-of-range digit into B.
        idle(12);
        press_suma();
        b_err = n_err;
        press_digit(4'd12);
        check("digit12_value", second_num, 0);
        check("digit12_err", n_err - b_err, 1);

        // suma with an empty A is ignored.
        idle(12);
        do_reset();
        b_add = n_add; b_start = n_start;
        press_suma();
        idle(5);
        check("empty_suma_add", n_add - b_add, 0);
        check("empty_suma_start", n_start - b_start, 0);
        check("empty_suma_phase", m_phase, PH_A);

        // Two digits while the converter is busy: one extra start after done.
        conv_delay = 10;
        idle(12);
        b_start = n_start;
        press_digit(3); press_digit(7); press_digit(8);
        idle(20);
        check("busy_starts", n_start - b_start, 2);
        check("busy_operand", last_start_op, 378);
        check("busy_start_gap", last_start_gap, 1);
        check("busy_value", first_num, 378);

        // Reset while in CONV; the stale done must not move the FSM.
        idle(5);
        press_digit(1); press_suma(); press_digit(2); press_suma();
        wait_phase("reach_conv", PH_CONV, 50);
        do_reset();
        check("rst_first", first_num, 0);
        check("rst_second", second_num, 0);
        check("rst_disp_sel", disp_sel, 0);
        check("rst_conv_start", conv_start, 0);
        b_start = n_start;
        idle(25);
        check("rst_no_start", n_start - b_start, 0);
        check("rst_phase", m_phase, PH_A);
        press_digit(5);
        check("rst_then_digit", first_num, 5);

        // Randomized traffic against the model.
        idle(12);
        rand_delay = 1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            digit_btn = ($urandom % 4) == 0;
            digit_in  = ($urandom % 5) == 0 ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            suma_btn  = ($urandom % 8) == 0;
            rst       = ($urandom % 400) == 0;
        end
        @(negedge clk);
        digit_btn = 1'b0; suma_btn = 1'b0; rst = 1'b0;
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
